// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its address checks.
package fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] IMEM_BASE = 32'h0040_0000;
  localparam logic [31:0] IMEM_LAST = 32'h0040_4000;

  typedef logic [31:0] instr_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_range_check.sv
// Combinational legality check: word-aligned and inside [BASE, LAST] inclusive.
module pc_range_check
  import fetch_pkg::*;
#(
  parameter logic [31:0] BASE = IMEM_BASE,
  parameter logic [31:0] LAST = IMEM_LAST
) (
  input  logic [31:0] pc,
  output logic        legal
);

  assign legal = (pc[1:0] == 2'b00) && (pc >= BASE) && (pc <= LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, combinational imem read, registered valid/ready output
// stage with redirect flush and illegal-PC fault latch.
module instruction_fetch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  instr_t      imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output instr_t      out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         out_valid_n;
  instr_t       out_instr_n;
  logic [31:0]  out_pc_n, fault_pc_n, fetch_count_n;
  logic         pc_legal, slot_free, handshake;

  pc_range_check #(.BASE(IMEM_BASE), .LAST(IMEM_LAST)) u_range (
    .pc    (pc),
    .legal (pc_legal)
  );

  assign imem_addr    = pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign fault        = (state == FAULT);
  assign slot_free    = !out_valid || out_ready;
  assign handshake    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      out_valid   <= out_valid_n;
      out_instr   <= out_instr_n;
      out_pc      <= out_pc_n;
      fault_pc    <= fault_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    out_valid_n   = out_valid;
    out_instr_n   = out_instr;
    out_pc_n      = out_pc;
    fault_pc_n    = fault_pc;
    // Handshakes count even when a redirect flushes the same instruction.
    fetch_count_n = fetch_count + {31'd0, handshake};

    if (redirect_valid) begin
      // Illegal targets are accepted here; the fault surfaces on the next free slot.
      state_n     = RUN;
      pc_n        = redirect_pc;
      out_valid_n = 1'b0;
    end else if (state == RUN && slot_free) begin
      if (pc_legal) begin
        out_instr_n = imem_instr;
        out_pc_n    = pc;
        out_valid_n = 1'b1;
        pc_n        = pc + 32'd4;
      end else begin
        state_n     = FAULT;
        fault_pc_n  = pc;
        out_valid_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns addr ^ 32'hDEAD_BEEF.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " out_instr"}, out_instr, 32'd0);
    chk({tag, " out_pc"}, out_pc, 32'd0);
    chk({tag, " out_pc_plus4"}, out_pc_plus4, 32'd4);
    chk({tag, " fault"}, {31'd0, fault}, 32'd0);
    chk({tag, " fault_pc"}, fault_pc, 32'd0);
    chk({tag, " fetch_count"}, fetch_count, 32'd0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0040_0000);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    chk_reset("rst");

    // Sequential fetch A, B, C
    rst_n = 1'b1;
    step();
    chk("a valid", {31'd0, out_valid}, 32'd1);
    chk("a pc", out_pc, 32'h0040_0000);
    chk("a instr", out_instr, 32'hDEED_BEEF);
    chk("a pc4", out_pc_plus4, 32'h0040_0004);
    step();
    chk("b pc", out_pc, 32'h0040_0004);
    chk("b instr", out_instr, 32'hDEED_BEEB);
    chk("b cnt", fetch_count, 32'd1);
    step();
    chk("c pc", out_pc, 32'h0040_0008);
    chk("c instr", out_instr, 32'hDEED_BEE7);
    step();
    chk("d pc", out_pc, 32'h0040_000C);
    chk("cnt3", fetch_count, 32'd3);

    // Stall for four cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall pc", out_pc, 32'h0040_000C);
      chk("stall instr", out_instr, 32'hDEED_BEE3);
      chk("stall addr", imem_addr, 32'h0040_0010);
      chk("stall cnt", fetch_count, 32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("resume pc", out_pc, 32'h0040_0010);
    chk("resume cnt", fetch_count, 32'd4);

    // Redirect while holding an instruction: one bubble
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    step();
    redirect_valid = 1'b0;
    chk("redir bubble", {31'd0, out_valid}, 32'd0);
    chk("redir addr", imem_addr, 32'h0040_0100);
    chk("redir cnt", fetch_count, 32'd5);
    step();
    chk("redir valid", {31'd0, out_valid}, 32'd1);
    chk("redir pc", out_pc, 32'h0040_0100);
    chk("redir instr", out_instr, 32'hDEED_BFEF);
    chk("redir cnt2", fetch_count, 32'd5);

    // Misaligned redirect faults one cycle later
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis nofault yet", {31'd0, fault}, 32'd0);
    step();
    chk("mis fault", {31'd0, fault}, 32'd1);
    chk("mis fault_pc", fault_pc, 32'h0040_0102);
    chk("mis valid", {31'd0, out_valid}, 32'd0);
    step(); step();
    chk("mis hold fault", {31'd0, fault}, 32'd1);
    chk("mis hold valid", {31'd0, out_valid}, 32'd0);
    chk("mis hold addr", imem_addr, 32'h0040_0102);
    chk("mis cnt", fetch_count, 32'd6);

    // Recover by redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    step();
    redirect_valid = 1'b0;
    chk("rec fault", {31'd0, fault}, 32'd0);
    chk("rec fault_pc", fault_pc, 32'h0040_0102);
    step();
    chk("rec valid", {31'd0, out_valid}, 32'd1);
    chk("rec pc", out_pc, 32'h0040_0000);

    // Run up to the last legal word, then fault on the range check
    redirect_valid = 1'b1; redirect_pc = 32'h0040_3FF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("end pc0", out_pc, 32'h0040_3FF8);
    step();
    chk("end pc1", out_pc, 32'h0040_3FFC);
    step();
    chk("last pc", out_pc, 32'h0040_4000);
    chk("last instr", out_instr, 32'hDEED_FEEF);
    chk("last valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("range fault", {31'd0, fault}, 32'd1);
    chk("range fault_pc", fault_pc, 32'h0040_4004);
    chk("range valid", {31'd0, out_valid}, 32'd0);
    chk("range cnt", fetch_count, 32'd10);

    // Reset during fault dominates a concurrent redirect
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    step();
    rst_n = 1'b1; redirect_valid = 1'b0;
    chk_reset("rst2");
    step();
    chk("post rst pc", out_pc, 32'h0040_0000);
    chk("post rst valid", {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: the initiator side of the instruction-memory read interface. Holds the program counter, drives a byte address to the combinational, word-indexed instruction memory, and registers the returned word into a valid/ready output stage for decode. Sits between the instruction memory and the decode stage. Handles stall (backpressure), redirect (branch/jump), and illegal-PC detection.

## Interface
- RESET_PC, 32'h0040_0000, byte address loaded into the PC at reset
- IMEM_BASE, 32'h0040_0000, lowest legal byte address (memory word index 32'h10_0000)
- IMEM_LAST, 32'h0040_4000, highest legal byte address, inclusive (word index 32'h10_1000)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_addr  out  32  byte address to instruction memory; memory indexes word `addr >> 2` and returns data in the same cycle
- imem_instr  in  32  instruction word from memory, combinational on imem_addr
- redirect_valid  in  1  load a new PC this cycle (branch/jump taken)
- redirect_pc  in  32  target byte address
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts when out_valid && out_ready
- out_instr  out  32  fetched instruction word
- out_pc  out  32  byte address of out_instr
- out_pc_plus4  out  32  out_pc + 4, mod 2^32
- fault  out  1  fetch stopped on illegal PC
- fault_pc  out  32  the offending PC
- fetch_count  out  32  number of accepted handshakes, wraps at 2^32

## Operation
- Registers: pc, state {RUN, FAULT}, output stage (out_valid, out_instr, out_pc), fault_pc, fetch_count.
- imem_addr = pc, driven combinationally.
- legal(pc) = pc[1:0] == 0 && IMEM_BASE <= pc <= IMEM_LAST.
- slot_free = !out_valid || out_ready.
- Per-cycle priority, highest first:
  1. rst_n == 0: pc <= RESET_PC; state <= RUN; out_valid <= 0; out_instr, out_pc <= 0; fault_pc <= 0; fetch_count <= 0.
  2. redirect_valid: pc <= redirect_pc; out_valid <= 0 (flushes the held instruction, even if it is being handshaked this cycle); state <= RUN; fault_pc is unchanged. No capture this cycle. fetch_count still increments if out_valid && out_ready.
  3. RUN && slot_free && legal(pc): out_instr <= imem_instr; out_pc <= pc; out_valid <= 1; pc <= pc + 4.
  4. RUN && slot_free && !legal(pc): state <= FAULT; fault_pc <= pc; out_valid <= 0; pc holds.
  5. RUN && !slot_free: all state holds (stall).
  6. FAULT: pc and outputs hold, out_valid stays 0; only redirect or reset leaves.
- fault = (state == FAULT).
- fetch_count increments on every out_valid && out_ready that is not under reset.
- A redirect to an illegal PC is accepted. The fault is raised on the next cycle in which the slot is free.

## Timing
- Reset values: out_valid 0, out_instr 0, out_pc 0, out_pc_plus4 4, fault 0, fault_pc 0, fetch_count 0, imem_addr RESET_PC.
- Latency: the first edge with rst_n == 1 captures RESET_PC. out_valid is 1 after that edge.
- Throughput is 1 instruction per cycle while out_ready is held high. Redirect costs exactly one bubble cycle.
- Held outputs are stable while out_valid && !out_ready. They change only on handshake, redirect, or reset.
- PC wrap: pc + 4 wraps mod 2^32. Reaching IMEM_LAST + 4 faults by the range check, not by the wrap.
- Reset asserted mid-stall or mid-fault dominates everything, including a concurrent redirect.

## Structure
- Shared package fetch_pkg holds:
  - RESET_PC, IMEM_BASE, IMEM_LAST defaults
  - the state enum {RUN, FAULT}
  - an `instr_t` 32-bit typedef
- One natural sub-module: pc_range_check, combinational, pc -> legal. It is reused later by the data-memory address checker.

## Test plan
- Reset release, out_ready = 1, memory preloaded with words A, B, C at 0x0040_0000, 0x0040_0004, 0x0040_0008 -> out_pc is 0x0040_0000, then 0x0040_0004, then 0x0040_0008 on consecutive cycles. out_instr is A, B, C. fetch_count is 3 after three handshakes.
- out_ready low for 4 cycles while out_valid = 1 -> out_instr, out_pc, and imem_addr unchanged; fetch_count unchanged. Resume -> next out_pc = previous + 4, with no skip and no duplicate.
- redirect_valid with redirect_pc = 0x0040_0100 while an instruction is held -> out_valid is 0 for one cycle, then out_pc = 0x0040_0100.
- Redirect to 0x0040_0102 (misaligned) -> fault = 1 and fault_pc = 0x0040_0102 one cycle later. out_valid stays 0. A later redirect to 0x0040_0000 clears fault, and fetch resumes.
- Sequential fetch reaching 0x0040_4000 -> that word is delivered. Then fault = 1 with fault_pc = 0x0040_4004.
- rst_n low for one cycle during fault with concurrent redirect_valid -> all outputs at reset values, pc = RESET_PC, redirect ignored.
